// File: rtl/phase_ctl.sv
// Consumer side of the one-hot five-phase sequencer. It gates the per-stage
// enables, counts retired instructions, and raises hlt back to the generator.
//
// state  | meaning
// IDLE   | waiting for the warm-up F that starts a run
// RUN    | tracking the expected phase, enabling stages, counting retires
// HALTED | stopped after a completed W; waits for resume without ext_halt
// ERR    | phase protocol violated; sticky until rst
module phase_ctl #(
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] HALT_OP = {OP_W{1'b1}},
    parameter int              CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       phase,
    input  logic [OP_W-1:0]  opcode,
    input  logic             ext_halt,
    input  logic             resume,
    output logic             hlt,
    output logic [4:0]       stage_en,
    output logic [CNT_W-1:0] inst_cnt,
    output logic             seq_err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [4:0] PH_F = 5'b00001;
    localparam logic [4:0] PH_R = 5'b00010;
    localparam logic [4:0] PH_X = 5'b00100;
    localparam logic [4:0] PH_W = 5'b10000;

    state_t           st_q, st_d;
    logic [4:0]       exp_q, exp_d;
    logic             pend_q, pend_d;
    logic             hlt_q, hlt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             phase_ok;
    logic             halt_req;

    // exact compare also rejects zero and multi-hot vectors
    assign phase_ok = (phase == exp_q);
    assign halt_req = ext_halt || ((phase == PH_X) && (opcode == HALT_OP));

    always_comb begin
        st_d   = st_q;
        exp_d  = exp_q;
        pend_d = pend_q;
        hlt_d  = hlt_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        case (st_q)
            S_IDLE: begin
                if (phase == PH_F) begin
                    st_d  = S_RUN;
                    exp_d = PH_R;
                end else if (phase != 5'b00000) begin
                    st_d  = S_ERR;
                    err_d = 1'b1;
                    hlt_d = 1'b1;
                end
            end
            S_RUN: begin
                if (phase_ok) begin
                    exp_d = {exp_q[3:0], exp_q[4]};
                    if (halt_req)
                        pend_d = 1'b1;
                    if (phase == PH_W) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        // the retiring instruction still counts; the next one never starts
                        if (pend_q || halt_req) begin
                            st_d  = S_HALTED;
                            hlt_d = 1'b1;
                        end
                    end
                end else begin
                    st_d  = S_ERR;
                    err_d = 1'b1;
                    hlt_d = 1'b1;
                end
            end
            S_HALTED: begin
                if (resume && !ext_halt) begin
                    st_d   = S_IDLE;
                    hlt_d  = 1'b0;
                    pend_d = 1'b0;
                    exp_d  = PH_F;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= S_IDLE;
            exp_q  <= PH_F;
            pend_q <= 1'b0;
            hlt_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            exp_q  <= exp_d;
            pend_q <= pend_d;
            hlt_q  <= hlt_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign stage_en = ((st_q == S_RUN) && phase_ok) ? phase : 5'b00000;
    assign hlt      = hlt_q;
    assign inst_cnt = cnt_q;
    assign seq_err  = err_q;
    assign state    = st_q;

endmodule

// File: tb/tb_phase_ctl.sv
// Bench for phase_ctl: vector table with a scoreboard queue, plus a counter
// wrap sequence against a narrow-counter instance.
module tb_phase_ctl;

    localparam logic [4:0] F = 5'b00001;
    localparam logic [4:0] R = 5'b00010;
    localparam logic [4:0] X = 5'b00100;
    localparam logic [4:0] M = 5'b01000;
    localparam logic [4:0] W = 5'b10000;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2, ERR = 2'd3;

    logic        clk = 1'b0;
    logic        rst, ext_halt, resume;
    logic [4:0]  phase;
    logic [5:0]  opcode;
    logic        hlt, seq_err, hlt4, seq_err4;
    logic [4:0]  stage_en, stage_en4;
    logic [15:0] inst_cnt;
    logic [3:0]  inst_cnt4;
    logic [1:0]  state, state4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    phase_ctl dut (
        .clk(clk), .rst(rst), .phase(phase), .opcode(opcode),
        .ext_halt(ext_halt), .resume(resume), .hlt(hlt),
        .stage_en(stage_en), .inst_cnt(inst_cnt), .seq_err(seq_err),
        .state(state)
    );

    phase_ctl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .phase(phase), .opcode(opcode),
        .ext_halt(ext_halt), .resume(resume), .hlt(hlt4),
        .stage_en(stage_en4), .inst_cnt(inst_cnt4), .seq_err(seq_err4),
        .state(state4)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  ph;
        logic [5:0]  op;
        logic        eh;
        logic        rs;
        logic [4:0]  en;
        logic [1:0]  st;
        logic        hlt;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [1:0]  st;
        logic        hlt;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];

    function automatic vec_t v(logic rs_t, logic [4:0] ph, logic [5:0] op, logic eh,
                               logic rs, logic [4:0] en, logic [1:0] st, logic h,
                               logic [15:0] cnt, logic err);
        vec_t t;
        t.rst = rs_t; t.ph = ph; t.op = op; t.eh = eh; t.rs = rs;
        t.en = en; t.st = st; t.hlt = h; t.cnt = cnt; t.err = err;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, want);
        end
    endtask

    task automatic step(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk);
        rst = t.rst; phase = t.ph; opcode = t.op; ext_halt = t.eh; resume = t.rs;
        e.idx = idx; e.st = t.st; e.hlt = t.hlt; e.cnt = t.cnt; e.err = t.err;
        sbq.push_back(e);
        #1;
        chk("stage_en", idx, 32'(stage_en), 32'(t.en));
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("state", e.idx, 32'(state), 32'(e.st));
        chk("hlt", e.idx, 32'(hlt), 32'(e.hlt));
        chk("inst_cnt", e.idx, 32'(inst_cnt), 32'(e.cnt));
        chk("seq_err", e.idx, 32'(seq_err), 32'(e.err));
    endtask

    initial begin
        rst = 1'b1; phase = '0; opcode = '0; ext_halt = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk);

        // nominal run: three instructions, first F is warm-up
        tbl.push_back(v(1, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));
        tbl.push_back(v(0, F, 0, 0, 0, 0, RUN, 0, 0, 0));
        for (int k = 1; k <= 3; k++) begin
            tbl.push_back(v(0, R, 0, 0, 0, R, RUN, 0, 16'(k-1), 0));
            tbl.push_back(v(0, X, 0, 0, 0, X, RUN, 0, 16'(k-1), 0));
            tbl.push_back(v(0, M, 0, 0, 0, M, RUN, 0, 16'(k-1), 0));
            tbl.push_back(v(0, W, 0, 0, 0, W, RUN, 0, 16'(k), 0));
            if (k < 3) tbl.push_back(v(0, F, 0, 0, 0, F, RUN, 0, 16'(k), 0));
        end

        // halt opcode in the X of instruction 2
        tbl.push_back(v(1, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));
        tbl.push_back(v(0, F, 0, 0, 0, 0, RUN, 0, 0, 0));
        tbl.push_back(v(0, R, 0, 0, 0, R, RUN, 0, 0, 0));
        tbl.push_back(v(0, X, 0, 0, 0, X, RUN, 0, 0, 0));
        tbl.push_back(v(0, M, 0, 0, 0, M, RUN, 0, 0, 0));
        tbl.push_back(v(0, W, 0, 0, 0, W, RUN, 0, 1, 0));
        tbl.push_back(v(0, F, 0, 0, 0, F, RUN, 0, 1, 0));
        tbl.push_back(v(0, R, 0, 0, 0, R, RUN, 0, 1, 0));
        tbl.push_back(v(0, X, 6'h3F, 0, 0, X, RUN, 0, 1, 0));
        tbl.push_back(v(0, M, 0, 0, 0, M, RUN, 0, 1, 0));
        tbl.push_back(v(0, W, 0, 0, 0, W, HALTED, 1, 2, 0));
        tbl.push_back(v(0, F, 0, 0, 0, 0, HALTED, 1, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, HALTED, 1, 2, 0));

        // ext_halt during R, then resume
        tbl.push_back(v(1, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));
        tbl.push_back(v(0, F, 0, 0, 0, 0, RUN, 0, 0, 0));
        tbl.push_back(v(0, R, 0, 1, 0, R, RUN, 0, 0, 0));
        tbl.push_back(v(0, X, 0, 0, 0, X, RUN, 0, 0, 0));
        tbl.push_back(v(0, M, 0, 0, 0, M, RUN, 0, 0, 0));
        tbl.push_back(v(0, W, 0, 0, 0, W, HALTED, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, IDLE, 0, 1, 0));
        tbl.push_back(v(0, F, 0, 0, 0, 0, RUN, 0, 1, 0));
        tbl.push_back(v(0, R, 0, 0, 0, R, RUN, 0, 1, 0));
        tbl.push_back(v(0, X, 0, 0, 0, X, RUN, 0, 1, 0));
        tbl.push_back(v(0, M, 0, 0, 0, M, RUN, 0, 1, 0));
        // halt request present in the W itself
        tbl.push_back(v(0, W, 0, 1, 0, W, HALTED, 1, 2, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, HALTED, 1, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, IDLE, 0, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, IDLE, 0, 2, 0));
        // pend cleared by IDLE entry; resume in RUN ignored
        tbl.push_back(v(0, F, 0, 0, 0, 0, RUN, 0, 2, 0));
        tbl.push_back(v(0, R, 0, 0, 1, R, RUN, 0, 2, 0));
        tbl.push_back(v(0, X, 0, 0, 0, X, RUN, 0, 2, 0));
        tbl.push_back(v(0, M, 0, 0, 0, M, RUN, 0, 2, 0));
        tbl.push_back(v(0, W, 0, 0, 0, W, RUN, 0, 3, 0));
        tbl.push_back(v(0, F, 0, 0, 0, F, RUN, 0, 3, 0));
        // protocol error: X while R expected; count frozen, resume ignored
        tbl.push_back(v(0, X, 0, 0, 0, 0, ERR, 1, 3, 1));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, ERR, 1, 3, 1));
        tbl.push_back(v(0, F, 0, 0, 0, 0, ERR, 1, 3, 1));
        tbl.push_back(v(0, W, 0, 0, 0, 0, ERR, 1, 3, 1));
        tbl.push_back(v(1, R, 0, 0, 0, 0, IDLE, 0, 0, 0));
        // IDLE sees a non-F phase
        tbl.push_back(v(0, R, 0, 0, 0, 0, ERR, 1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));
        // multi-hot in RUN
        tbl.push_back(v(0, F, 0, 0, 0, 0, RUN, 0, 0, 0));
        tbl.push_back(v(0, 5'b00110, 0, 0, 0, 0, ERR, 1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));
        // zero phase in RUN
        tbl.push_back(v(0, F, 0, 0, 0, 0, RUN, 0, 0, 0));
        tbl.push_back(v(0, R, 0, 0, 0, R, RUN, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, ERR, 1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));
        // reset mid-instruction after a retire
        tbl.push_back(v(0, F, 0, 0, 0, 0, RUN, 0, 0, 0));
        tbl.push_back(v(0, R, 0, 0, 0, R, RUN, 0, 0, 0));
        tbl.push_back(v(0, X, 0, 0, 0, X, RUN, 0, 0, 0));
        tbl.push_back(v(0, M, 0, 0, 0, M, RUN, 0, 0, 0));
        tbl.push_back(v(0, W, 0, 0, 0, W, RUN, 0, 1, 0));
        tbl.push_back(v(0, F, 0, 0, 0, F, RUN, 0, 1, 0));
        tbl.push_back(v(1, R, 0, 0, 0, R, IDLE, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, IDLE, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], i);

        // counter wrap on the 4-bit instance across 17 instructions
        step(v(1, 0, 0, 0, 0, 0, IDLE, 0, 0, 0), 1000);
        step(v(0, F, 0, 0, 0, 0, RUN, 0, 0, 0), 1001);
        for (int i = 1; i <= 17; i++) begin
            logic [3:0] want4;
            want4 = 4'(i % 16);
            step(v(0, R, 0, 0, 0, R, RUN, 0, 16'(i-1), 0), 1000 + 10*i);
            step(v(0, X, 0, 0, 0, X, RUN, 0, 16'(i-1), 0), 1001 + 10*i);
            step(v(0, M, 0, 0, 0, M, RUN, 0, 16'(i-1), 0), 1002 + 10*i);
            step(v(0, W, 0, 0, 0, W, RUN, 0, 16'(i), 0), 1003 + 10*i);
            chk("wrap_cnt4", i, 32'(inst_cnt4), 32'(want4));
            chk("wrap_err4", i, 32'(seq_err4), 32'd0);
            step(v(0, F, 0, 0, 0, F, RUN, 0, 16'(i), 0), 1004 + 10*i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
